// File: rtl/sd_cmd_tx.sv
// sd_cmd_tx: host-side SD CMD-line transmitter.
// Serializes one 48-bit command token (start, transmission, index, argument,
// CRC7, end) MSB first, paced by bit_en, then holds CMD released for GAP_BITS
// bit periods before reporting done.
// Ports:
//   clk, reset     system clock, asynchronous active-high reset
//   bit_en         one-cycle strobe per SD clock period
//   start          command request, honoured only while idle
//   cmd_index/arg  token contents, captured on an accepted start
//   cmd_out/oe     serial data and output enable to the CMD pad
//   busy           high from accepted start until done
//   done           one-cycle pulse once token and gap have completed
module sd_cmd_tx #(
    parameter int unsigned GAP_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bit_en,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        cmd_out,
    output logic        cmd_oe,
    output logic        busy,
    output logic        done
);

    localparam int unsigned SR_W  = 40;
    localparam int unsigned CRC_W = 7;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned GAP_W = $clog2(GAP_BITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               out_q, out_d;
    logic               oe_q, oe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // CRC7 (x^7 + x^3 + 1) advanced by the frame bit currently leaving the shift register
    logic               crc_fb;
    logic [CRC_W-1:0]   crc_next;

    assign crc_fb   = crc_q[6] ^ sr_q[SR_W-1];
    assign crc_next = {crc_q[5:3], crc_q[2] ^ crc_fb, crc_q[1:0], crc_fb};

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            crc_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            out_q   <= 1'b1;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        out_d   = out_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // Capture is independent of bit_en so the token is frozen immediately
                if (start) begin
                    sr_d    = {1'b0, 1'b1, cmd_index, cmd_arg};
                    crc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end

            LOAD: begin
                if (bit_en) begin
                    out_d   = sr_q[SR_W-1];
                    oe_d    = 1'b1;
                    crc_d   = crc_next;
                    sr_d    = {sr_q[SR_W-2:0], 1'b0};
                    cnt_d   = CNT_W'(47);
                    state_d = SEND;
                end
            end

            SEND: begin
                if (bit_en) begin
                    if (cnt_q == '0) begin
                        // End bit has had its full period; release the line
                        out_d   = 1'b1;
                        oe_d    = 1'b0;
                        gap_d   = GAP_W'(GAP_BITS);
                        state_d = GAP;
                    end else begin
                        // cnt_q is the bit on the wire; the bit driven now is cnt_q-1
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q > CNT_W'(8)) begin
                            out_d = sr_q[SR_W-1];
                            crc_d = crc_next;
                            sr_d  = {sr_q[SR_W-2:0], 1'b0};
                        end else if (cnt_q > CNT_W'(1)) begin
                            out_d = crc_q[CRC_W-1];
                            crc_d = {crc_q[CRC_W-2:0], 1'b0};
                        end else begin
                            out_d = 1'b1;
                        end
                    end
                end
            end

            GAP: begin
                if (bit_en) begin
                    gap_d = gap_q - GAP_W'(1);
                    if (gap_q == GAP_W'(1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign cmd_out = out_q;
    assign cmd_oe  = oe_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Directed bench for sd_cmd_tx: default-gap and 16-bit-gap instances.
module tb_sd_cmd_tx;

    logic        clk;
    logic        reset;
    logic        bit_en;
    logic        start8;
    logic        start16;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        out8, oe8, busy8, done8;
    logic        out16, oe16, busy16, done16;

    int checks = 0;
    int errors = 0;

    sd_cmd_tx #(.GAP_BITS(8)) dut (
        .clk(clk), .reset(reset), .bit_en(bit_en), .start(start8),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .cmd_out(out8), .cmd_oe(oe8), .busy(busy8), .done(done8)
    );

    sd_cmd_tx #(.GAP_BITS(16)) dut16 (
        .clk(clk), .reset(reset), .bit_en(bit_en), .start(start16),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .cmd_out(out16), .cmd_oe(oe16), .busy(busy16), .done(done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command and capture the wire; optional mid-token start/arg
    // disturbance at strobe 20 and optional reset at strobe rst_at.
    task automatic run_cmd(
        input  string       tag,
        input  logic [5:0]  idx,
        input  logic [31:0] arg,
        input  int          period,
        input  bit          use16,
        input  bit          inject,
        input  int          rst_at,
        output logic [47:0] tok,
        output int          oe_in,
        output int          oe_out,
        output int          done_at
    );
        int  s = 0;
        bit  fin = 0;
        logic o, e, b, d;
        tok = '0; oe_in = 0; oe_out = 0; done_at = -1;
        bit_en = 1'b0;
        cmd_index = idx;
        cmd_arg   = arg;
        if (use16) start16 = 1'b1; else start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; start16 = 1'b0;
        check({tag, "_busy_latency"}, 64'(use16 ? busy16 : busy8), 64'd1);
        for (int c = 0; c < 80 * period && !fin; c++) begin
            bit_en = ((c % period) == period - 1);
            if (bit_en) s++;
            if (inject && bit_en && s == 20) begin
                if (use16) start16 = 1'b1; else start8 = 1'b1;
                cmd_index = ~idx;
                cmd_arg   = ~arg;
            end
            @(posedge clk); #1;
            start8 = 1'b0; start16 = 1'b0;
            o = use16 ? out16 : out8;
            e = use16 ? oe16  : oe8;
            b = use16 ? busy16 : busy8;
            d = use16 ? done16 : done8;
            if (bit_en) begin
                if (s <= 48) begin
                    tok = {tok[46:0], o};
                    if (e) oe_in++;
                end else if (e) begin
                    oe_out++;
                end
            end
            if (d) begin
                done_at = s;
                fin = 1;
                check({tag, "_busy_after_done"}, 64'(b), 64'd0);
            end
            if (rst_at > 0 && bit_en && s == rst_at) begin
                reset = 1'b1;
                #1;
                check({tag, "_rst_oe"},   64'(use16 ? oe16 : oe8),     64'd0);
                check({tag, "_rst_out"},  64'(use16 ? out16 : out8),   64'd1);
                check({tag, "_rst_busy"}, 64'(use16 ? busy16 : busy8), 64'd0);
                @(posedge clk); #1;
                reset = 1'b0;
                fin = 1;
            end
        end
        bit_en = 1'b0;
    endtask

    logic [47:0] tok;
    int oe_in, oe_out, done_at;

    initial begin
        reset = 1'b1; bit_en = 1'b0; start8 = 1'b0; start16 = 1'b0;
        cmd_index = '0; cmd_arg = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_out", 64'(out8),  64'd1);
        check("rst_cmd_oe",  64'(oe8),   64'd0);
        check("rst_busy",    64'(busy8), 64'd0);
        check("rst_done",    64'(done8), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // CMD0, strobe every 4 clk
        run_cmd("cmd0", 6'd0, 32'h0, 4, 0, 0, 0, tok, oe_in, oe_out, done_at);
        check("cmd0_token",  64'(tok),     64'h4000000000_95);
        check("cmd0_oe_in",  64'(oe_in),   64'd48);
        check("cmd0_oe_out", 64'(oe_out),  64'd0);
        check("cmd0_done",   64'(done_at), 64'd57);

        // CMD8 and CMD17 CRC coverage
        run_cmd("cmd8", 6'd8, 32'h000001AA, 3, 0, 0, 0, tok, oe_in, oe_out, done_at);
        check("cmd8_token", 64'(tok),     64'h48000001AA_87);
        check("cmd8_done",  64'(done_at), 64'd57);
        run_cmd("cmd17", 6'd17, 32'h0, 2, 0, 0, 0, tok, oe_in, oe_out, done_at);
        check("cmd17_token", 64'(tok), 64'h5100000000_55);

        // Start and argument change mid-token must not disturb CMD8
        run_cmd("cmd8_inj", 6'd8, 32'h000001AA, 4, 0, 1, 0, tok, oe_in, oe_out, done_at);
        check("cmd8_inj_token", 64'(tok),     64'h48000001AA_87);
        check("cmd8_inj_done",  64'(done_at), 64'd57);
        check("cmd8_inj_idle",  64'(busy8),   64'd0);

        // bit_en held high, then back-to-back start on the clk after done
        run_cmd("b2b_a", 6'd17, 32'h0, 1, 0, 0, 0, tok, oe_in, oe_out, done_at);
        check("b2b_a_token", 64'(tok),     64'h5100000000_55);
        check("b2b_a_done",  64'(done_at), 64'd57);
        run_cmd("b2b_b", 6'd8, 32'h000001AA, 1, 0, 0, 0, tok, oe_in, oe_out, done_at);
        check("b2b_b_token", 64'(tok),     64'h48000001AA_87);
        check("b2b_b_oe_in", 64'(oe_in),   64'd48);
        check("b2b_b_done",  64'(done_at), 64'd57);

        // Reset at strobe 30 of CMD17, then a clean CMD0
        run_cmd("rst17", 6'd17, 32'h0, 2, 0, 0, 30, tok, oe_in, oe_out, done_at);
        run_cmd("post_rst", 6'd0, 32'h0, 2, 0, 0, 0, tok, oe_in, oe_out, done_at);
        check("post_rst_token", 64'(tok),     64'h4000000000_95);
        check("post_rst_done",  64'(done_at), 64'd57);

        // 16-bit gap instance
        run_cmd("gap16", 6'd0, 32'h0, 2, 1, 0, 0, tok, oe_in, oe_out, done_at);
        check("gap16_token",  64'(tok),     64'h4000000000_95);
        check("gap16_oe_in",  64'(oe_in),   64'd48);
        check("gap16_oe_out", 64'(oe_out),  64'd0);
        check("gap16_done",   64'(done_at), 64'd65);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_cmd_tx.md
# sd_cmd_tx

Host-side SD command-line transmitter. It serializes one 48-bit SD command token onto the CMD line: start bit, transmission bit, index, argument, CRC7 and end bit. It then enforces the inter-command idle gap. It is the issuing counterpart of the card-state tracking FSM. That FSM advances on CMD2/3/7/12/17/24 and similar commands, and this block puts those commands on the wire. Bit timing is paced by an external SD-clock strobe, so the block runs entirely in the system clock domain.

## Interface
- GAP_BITS, 8, number of bit periods CMD is released (high-Z, pulled up) after the end bit before the next command may start (Ncc ≥ 8).
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- bit_en  input  1  one-cycle strobe, one per SD clock period; CMD output changes only on edges where bit_en=1.
- start  input  1  request to send a command; sampled only when busy=0.
- cmd_index  input  6  command index, latched on accepted start.
- cmd_arg  input  32  command argument, latched on accepted start.
- cmd_out  output  1  serial CMD data to the pad.
- cmd_oe  output  1  pad output enable (1 = host drives CMD).
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse when the token and gap are complete.

## Operation
- All outputs are registered. Reset values: cmd_out=1, cmd_oe=0, busy=0, done=0, state IDLE, CRC=0.
- States: IDLE, LOAD, SEND, GAP.
- IDLE: if start=1, latch {1'b0, 1'b1, cmd_index, cmd_arg} into a 40-bit shift register, clear CRC, set busy=1, go to LOAD. This happens regardless of bit_en.
- start while busy=1 is ignored and does not queue.
- LOAD: on the first bit_en, drive frame bit 47 (start bit, 0), set cmd_oe=1, set bit counter=47, go to SEND.
- SEND: on each bit_en, decrement the counter and drive the next bit.
  - Bits 47..8 come from the shift register, MSB first. Each of these 40 bits feeds the CRC7.
  - CRC7 uses polynomial x^7+x^3+1, with feedback = crc[6] XOR data. Next crc = {crc[5:3], crc[2]^fb, crc[1:0], fb}.
  - Bits 7..1 are crc[6..0], shifted out MSB first.
  - Bit 0 is the end bit, 1.
- After bit 0 has been driven for one bit period, the next bit_en sets cmd_oe=0 and cmd_out=1, loads gap counter=GAP_BITS, and goes to GAP.
- GAP: decrement the gap counter on each bit_en. On the bit_en where it reaches 0, pulse done=1 for one clk, set busy=0 and return to IDLE.
- While busy=1, cmd_index and cmd_arg may change freely without affecting the token.
- bit_en held high continuously is legal: one bit per clk.
- bit_en=0 freezes all state and outputs except the IDLE→LOAD transition.
- Reset mid-token or mid-gap: outputs return to reset values immediately (asynchronous), and a partial frame is abandoned.

## Timing
- Counting bit_en strobes from the first one after start is accepted:
  - Strobe 1 drives the start bit.
  - Strobe 48 drives the end bit.
  - Strobe 49 releases the line.
  - Strobe 49+GAP_BITS pulses done and drops busy.
- With GAP_BITS=8 a command occupies 57 strobes.
- The earliest next start is the clk after done. Its start bit appears on the next bit_en.
- cmd_oe is high for exactly 48 bit periods per command.
- Latency from start to busy=1 is one clk.

## Test plan
- CMD0 with arg 0x00000000, bit_en every 4 clk → serial token 0x40_00000000_95. cmd_oe high for 48 strobes, done at strobe 57.
- CMD8 with arg 0x000001AA → token 0x48_000001AA_87. CMD17 with arg 0x00000000 → 0x51_00000000_55, covering the CRC7 check.
- Pulse start at strobe 20 of an active CMD8 → ignored, token unchanged. Change cmd_arg mid-token → no effect on the token.
- bit_en held at 1 → full token in 48 consecutive clk, done 57 clk after LOAD. Then start asserted on the clk after done → a second token starts cleanly with no extra gap.
- Assert reset at strobe 30 of CMD17 → cmd_oe=0, cmd_out=1, busy=0 in the same cycle. A fresh CMD0 afterwards gives a correct 0x95 CRC, proving CRC state was cleared.
- GAP_BITS=16 → done at strobe 65, and cmd_oe stays 0 through strobes 49..65.
